// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI frame receiver: frame bit positions,
// default frame length and the receive state encoding.
package dac_spi_pkg;

    localparam int unsigned FRAME_BITS_DEFAULT = 16;

    // Bit positions inside a 16-bit DAC frame (bit 15 is sent first)
    localparam int unsigned AB_BIT   = 15;
    localparam int unsigned BUF_BIT  = 14;
    localparam int unsigned GA_BIT   = 13;
    localparam int unsigned SHDN_BIT = 12;
    localparam int unsigned DATA_MSB = 11;
    localparam int unsigned DATA_LSB = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with registered edge pulses.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised level
//   rise, fall : one-cycle pulses, asserted in the cycle q takes its new value
// SYNC_STAGES must be at least 2.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    // Edge pulses compare the stage feeding q with q itself, so each pulse
    // lines up with the cycle in which q changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            rise  <= chain[SYNC_STAGES-2] & ~chain[SYNC_STAGES-1];
            fall  <= ~chain[SYNC_STAGES-2] & chain[SYNC_STAGES-1];
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/dac_spi_rx.sv
// Receiver for the serial DAC frame: synchronises SCK/CS/SDI/LD into sysclk,
// deserialises 16-bit frames, holds the last good frame as pending and
// copies it to the parallel outputs on an LD falling edge.
// Ports:
//   sysclk, rst_n           : clock, async active-low reset
//   dac_sck/cs/sdi/ld       : SPI pins (CS and LD active-low)
//   dac_value               : last loaded sample (0 when loaded in shutdown)
//   dac_buf/gain_n/shdn_n   : configuration bits of the last loaded frame
//   load_pulse              : one-cycle pulse when the outputs update
//   frame_err               : one-cycle pulse when a frame is rejected
//   busy                    : high while a frame is being shifted
module dac_spi_rx
    import dac_spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              dac_sck,
    input  logic              dac_cs,
    input  logic              dac_sdi,
    input  logic              dac_ld,
    output logic [DATA_W-1:0] dac_value,
    output logic              dac_buf,
    output logic              dac_gain_n,
    output logic              dac_shdn_n,
    output logic              load_pulse,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sck_q, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic sdi_q, sdi_rise, sdi_fall;
    logic ld_q, ld_rise, ld_fall;
    logic sync_unused;

    rx_state_t             state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  pend_valid;
    logic [DATA_W-1:0]     pend_value;
    logic                  pend_buf;
    logic                  pend_gain_n;
    logic                  pend_shdn_n;

    logic              frame_ok_c;
    logic              load_c;
    logic [DATA_W-1:0] src_value_c;
    logic              src_buf_c;
    logic              src_gain_n_c;
    logic              src_shdn_n_c;

    // Idle levels are used as reset values so releasing reset does not
    // fabricate CS or LD edges.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(sysclk), .rst_n(rst_n), .d(dac_sck),
        .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(sysclk), .rst_n(rst_n), .d(dac_cs),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(sysclk), .rst_n(rst_n), .d(dac_sdi),
        .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ld (
        .clk(sysclk), .rst_n(rst_n), .d(dac_ld),
        .q(ld_q), .rise(ld_rise), .fall(ld_fall)
    );

    assign sync_unused = ^{sck_q, sck_fall, sdi_rise, sdi_fall, ld_q, ld_rise};

    // Frame acceptance and load source; a frame completing in the same cycle
    // as an LD fall is forwarded straight to the outputs.
    always_comb begin
        frame_ok_c   = (state == SHIFT) && cs_rise && (bit_cnt == CNT_FULL)
                       && !shreg[AB_BIT];
        load_c       = ld_fall && cs_q && (pend_valid || frame_ok_c);
        src_value_c  = pend_value;
        src_buf_c    = pend_buf;
        src_gain_n_c = pend_gain_n;
        src_shdn_n_c = pend_shdn_n;
        if (frame_ok_c) begin
            src_value_c  = shreg[DATA_LSB +: DATA_W];
            src_buf_c    = shreg[BUF_BIT];
            src_gain_n_c = shreg[GA_BIT];
            src_shdn_n_c = shreg[SHDN_BIT];
        end
    end

    // Receive FSM, pending register and output registers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            pend_valid  <= 1'b0;
            pend_value  <= '0;
            pend_buf    <= 1'b0;
            pend_gain_n <= 1'b1;
            pend_shdn_n <= 1'b1;
            dac_value   <= '0;
            dac_buf     <= 1'b0;
            dac_gain_n  <= 1'b1;
            dac_shdn_n  <= 1'b1;
            load_pulse  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (frame_ok_c) begin
                            pend_valid  <= 1'b1;
                            pend_value  <= src_value_c;
                            pend_buf    <= src_buf_c;
                            pend_gain_n <= src_gain_n_c;
                            pend_shdn_n <= src_shdn_n_c;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        shreg <= {shreg[FRAME_BITS-2:0], sdi_q};
                        // Saturating count keeps over-long frames distinguishable
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Placed after the FSM so a same-cycle load consumes the new frame
            if (load_c) begin
                dac_value  <= src_shdn_n_c ? src_value_c : '0;
                dac_buf    <= src_buf_c;
                dac_gain_n <= src_gain_n_c;
                dac_shdn_n <= src_shdn_n_c;
                load_pulse <= 1'b1;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: directed SPI frames plus a pin-level reference model
// that predicts every output cycle by cycle.
module tb_dac_spi_rx;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       dac_sck = 1'b0;
    logic       dac_cs  = 1'b1;
    logic       dac_sdi = 1'b0;
    logic       dac_ld  = 1'b1;
    logic [9:0] dac_value;
    logic       dac_buf, dac_gain_n, dac_shdn_n, load_pulse, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int n_load = 0;
    int n_err  = 0;

    dac_spi_rx dut (
        .sysclk    (clk),
        .rst_n     (rst_n),
        .dac_sck   (dac_sck),
        .dac_cs    (dac_cs),
        .dac_sdi   (dac_sdi),
        .dac_ld    (dac_ld),
        .dac_value (dac_value),
        .dac_buf   (dac_buf),
        .dac_gain_n(dac_gain_n),
        .dac_shdn_n(dac_shdn_n),
        .load_pulse(load_pulse),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pins seen by the model are delayed by two samples and edges are taken
    // between samples k-3 and k-2, giving the 3-cycle pin-to-output latency.
    logic [3:0] h_cs = 4'hF, h_ld = 4'hF, h_sck = 4'h0, h_sdi = 4'h0;
    bit         m_in_frame = 1'b0;
    bit         m_bits[$];
    bit         m_pend_valid = 1'b0;
    int         m_pend_word = 0;
    int         exp_value = 0;
    bit         exp_buf = 1'b0, exp_gain_n = 1'b1, exp_shdn_n = 1'b1;
    bit         exp_load = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cs = 4'hF; h_ld = 4'hF; h_sck = 4'h0; h_sdi = 4'h0;
            m_in_frame = 1'b0; m_bits.delete(); m_pend_valid = 1'b0;
            exp_value = 0; exp_buf = 1'b0; exp_gain_n = 1'b1; exp_shdn_n = 1'b1;
            exp_load = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        end else begin
            h_cs  = {h_cs[2:0], dac_cs};
            h_ld  = {h_ld[2:0], dac_ld};
            h_sck = {h_sck[2:0], dac_sck};
            h_sdi = {h_sdi[2:0], dac_sdi};
            exp_load = 1'b0;
            exp_err  = 1'b0;
            if (h_cs[3] && !h_cs[2]) begin
                m_in_frame = 1'b1;
                m_bits.delete();
                exp_busy = 1'b1;
            end else if (m_in_frame && !h_cs[3] && h_cs[2]) begin
                m_in_frame = 1'b0;
                exp_busy = 1'b0;
                if (m_bits.size() == 16 && m_bits[0] == 1'b0) begin
                    m_pend_word = 0;
                    foreach (m_bits[i]) m_pend_word = m_pend_word * 2 + int'(m_bits[i]);
                    m_pend_valid = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end else if (m_in_frame && !h_sck[3] && h_sck[2]) begin
                m_bits.push_back(h_sdi[2]);
            end
            if (h_ld[3] && !h_ld[2] && h_cs[2] && m_pend_valid) begin
                exp_buf    = ((m_pend_word >> 14) & 1) == 1;
                exp_gain_n = ((m_pend_word >> 13) & 1) == 1;
                exp_shdn_n = ((m_pend_word >> 12) & 1) == 1;
                exp_value  = exp_shdn_n ? ((m_pend_word >> 2) & 'h3FF) : 0;
                exp_load   = 1'b1;
                m_pend_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse counters
    always @(negedge clk) begin
        chk("value",  32'(dac_value),  32'(exp_value));
        chk("buf",    32'(dac_buf),    32'(exp_buf));
        chk("gain_n", 32'(dac_gain_n), 32'(exp_gain_n));
        chk("shdn_n", 32'(dac_shdn_n), 32'(exp_shdn_n));
        chk("load",   32'(load_pulse), 32'(exp_load));
        chk("err",    32'(frame_err),  32'(exp_err));
        chk("busy",   32'(busy),       32'(exp_busy));
        if (load_pulse) n_load++;
        if (frame_err)  n_err++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #5;
        end
    endtask

    task automatic send_bit(input logic b);
        dac_sdi = b;
        tick(4);
        dac_sck = 1'b1;
        tick(4);
        dac_sck = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input int n, input bit mid_ld, input bit ld_with_cs);
        dac_cs = 1'b0;
        tick(4);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == n - 5) chk("busy_mid", 32'(busy), 32'd1);
            if (mid_ld && i == n - 6) begin
                dac_ld = 1'b0;
                tick(5);
                dac_ld = 1'b1;
                tick(1);
            end
        end
        tick(4);
        dac_cs = 1'b1;
        if (ld_with_cs) dac_ld = 1'b0;
        tick(5);
        dac_ld = 1'b1;
        tick(6);
    endtask

    task automatic ld_pulse();
        dac_ld = 1'b0;
        tick(5);
        dac_ld = 1'b1;
        tick(6);
    endtask

    initial begin
        int l0, e0;
        logic [9:0]  rd;
        logic        rb, rg;
        logic [15:0] rw;

        // Reset held with inputs toggling
        tick(2);
        for (int i = 0; i < 12; i++) begin
            {dac_sck, dac_sdi, dac_cs, dac_ld} = 4'(i * 5);
            tick(1);
        end
        dac_sck = 1'b0; dac_sdi = 1'b0; dac_cs = 1'b1; dac_ld = 1'b1;
        tick(2);
        chk("rst_value",  32'(dac_value),  32'h0);
        chk("rst_gain_n", 32'(dac_gain_n), 32'h1);
        chk("rst_shdn_n", 32'(dac_shdn_n), 32'h1);
        chk("rst_pulses", 32'(n_load + n_err), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // Valid frame, then LD with latency check
        send_frame(32'h3A94, 16, 1'b0, 1'b0);
        chk("busy_after", 32'(busy), 32'h0);
        l0 = n_load;
        dac_ld = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("ld_latency", 32'(load_pulse), 32'(i == 3));
        end
        @(posedge clk);
        #5;
        dac_ld = 1'b1;
        tick(6);
        chk("v1_value",  32'(dac_value),  32'h2A5);
        chk("v1_buf",    32'(dac_buf),    32'h0);
        chk("v1_gain_n", 32'(dac_gain_n), 32'h1);
        chk("v1_shdn_n", 32'(dac_shdn_n), 32'h1);
        chk("v1_loads",  32'(n_load - l0), 32'h1);

        // Short (12-bit) and long (18-bit) frames
        e0 = n_err; l0 = n_load;
        send_frame(32'h3A9, 12, 1'b0, 1'b0);
        send_frame(32'h03A94, 18, 1'b0, 1'b0);
        chk("len_errs", 32'(n_err - e0), 32'h2);
        ld_pulse();
        chk("len_noload", 32'(n_load - l0), 32'h0);
        chk("len_value",  32'(dac_value),   32'h2A5);

        // A/B set rejected; shutdown frame loads zero
        e0 = n_err;
        send_frame(32'hBA94, 16, 1'b0, 1'b0);
        chk("ab_err", 32'(n_err - e0), 32'h1);
        send_frame(32'h2A94, 16, 1'b0, 1'b0);
        ld_pulse();
        chk("shdn_value", 32'(dac_value),  32'h0);
        chk("shdn_n",     32'(dac_shdn_n), 32'h0);

        // Last writer wins; second LD with nothing pending
        l0 = n_load;
        send_frame(32'h3004, 16, 1'b0, 1'b0);
        send_frame(32'h3FFC, 16, 1'b0, 1'b0);
        ld_pulse();
        chk("lww_value", 32'(dac_value), 32'h3FF);
        chk("lww_loads", 32'(n_load - l0), 32'h1);
        ld_pulse();
        chk("nopend_loads", 32'(n_load - l0), 32'h1);

        // LD pulsed mid-frame is ignored
        l0 = n_load; e0 = n_err;
        send_frame(32'h3004, 16, 1'b1, 1'b0);
        chk("midld_noload", 32'(n_load - l0), 32'h0);
        chk("midld_noerr",  32'(n_err - e0),  32'h0);
        ld_pulse();
        chk("midld_value", 32'(dac_value), 32'h1);

        // CS rise and LD fall together: frame completes, then loads
        l0 = n_load;
        send_frame(32'h3FFC, 16, 1'b0, 1'b1);
        chk("sim_value", 32'(dac_value), 32'h3FF);
        chk("sim_loads", 32'(n_load - l0), 32'h1);
        ld_pulse();
        chk("sim_nopend", 32'(n_load - l0), 32'h1);

        // Reset after 8 bits, then a fresh frame
        dac_cs = 1'b0;
        tick(4);
        for (int i = 15; i >= 8; i--) begin
            rw = 16'h3FFC;
            send_bit(rw[i]);
        end
        rst_n = 1'b0;
        dac_cs = 1'b1; dac_sck = 1'b0; dac_sdi = 1'b0;
        tick(3);
        chk("mrst_value", 32'(dac_value), 32'h0);
        chk("mrst_busy",  32'(busy),      32'h0);
        rst_n = 1'b1;
        tick(4);
        send_frame(32'h3A94, 16, 1'b0, 1'b0);
        ld_pulse();
        chk("mrst_reload", 32'(dac_value), 32'h2A5);

        // Random valid frames
        for (int k = 0; k < 6; k++) begin
            rd = 10'($urandom_range(0, 1023));
            rb = 1'($urandom_range(0, 1));
            rg = 1'($urandom_range(0, 1));
            rw = {1'b0, rb, rg, 1'b1, rd, 2'($urandom_range(0, 3))};
            send_frame(32'(rw), 16, 1'b0, 1'b0);
            ld_pulse();
            chk("rnd_value",  32'(dac_value),  32'(rd));
            chk("rnd_buf",    32'(dac_buf),    32'(rb));
            chk("rnd_gain_n", 32'(dac_gain_n), 32'(rg));
        end

        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
